// File: rtl/segment_scheduler.sv
// rtl/segment_scheduler.sv - queued multi-segment run sequencer with bank-swap strobes and capture gating
// Optional looping replay of resident segments is enabled by defining SEGMENT_SCHEDULER_LOOP_EN.
module segment_scheduler #(
    parameter int DEPTH = 8,
    parameter int TW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [TW-1:0]            seg_din,
    input  logic                     seg_push,
    output logic                     seg_full,
    output logic [$clog2(DEPTH):0]   seg_count,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     fifo_full,
`ifdef SEGMENT_SCHEDULER_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     bank_swap,
    output logic                     capture_en,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               seg_index,
    output logic                     push_err,
    output logic                     ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, head_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] cnt, head_dur;
    logic          pop, push_ok, start_ok, more_load, more_run;

    assign pop      = (state == LOAD);
    assign start_ok = (state == IDLE) && start;
    assign seg_full = (count == CW'(DEPTH));
    assign seg_count = count;
    assign head_dur = mem[head_ptr];

`ifdef SEGMENT_SCHEDULER_LOOP_EN
    // pend counts entries not yet loaded in the current pass; a LOAD with
    // pend==0 rewinds lazily to the first resident entry (always slot 0).
    logic [CW-1:0] pend, avail_after_pop;
    logic          rewind;
    assign rewind          = (pend == '0);
    assign head_ptr        = rewind ? '0 : rd_ptr;
    assign avail_after_pop = (rewind ? count : pend) - 1'b1;
    assign more_load       = (avail_after_pop != '0) || (loop && count != '0);
    assign more_run        = (pend != '0) || (loop && count != '0);
    assign push_ok         = seg_push && !seg_full;
`else
    assign head_ptr  = rd_ptr;
    assign more_load = (count > CW'(1));
    assign more_run  = (count != '0);
    assign push_ok   = seg_push && (!seg_full || pop);
`endif

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= seg_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = (count != '0) ? LOAD : DONE;
            LOAD: begin
                if (head_dur != '0)  state_next = RUN;
                else if (more_load)  state_next = LOAD;
                else                 state_next = DONE;
            end
            RUN:  if (cnt == TW'(1)) state_next = more_run ? LOAD : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bank_swap  = (state == LOAD);
        capture_en = (state == RUN);
        busy       = (state == LOAD) || (state == RUN);
        done       = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            seg_index <= '0;
            push_err  <= 1'b0;
            ovf_err   <= 1'b0;
`ifdef SEGMENT_SCHEDULER_LOOP_EN
            pend      <= '0;
`endif
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
`ifdef SEGMENT_SCHEDULER_LOOP_EN
            pend   <= '0;
`endif
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (start_ok) begin
                seg_index <= '0;
                push_err  <= 1'b0;
                ovf_err   <= 1'b0;
            end
            if (seg_push && !push_ok) push_err <= 1'b1;
            if (capture_en && fifo_full) ovf_err <= 1'b1;
            if (pop) begin
                cnt       <= head_dur;
                seg_index <= seg_index + 1'b1;
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
            end
`ifdef SEGMENT_SCHEDULER_LOOP_EN
            if (push_ok) count <= count + 1'b1;
            if (start_ok) begin
                rd_ptr <= '0;
                pend   <= count + CW'(push_ok);
            end else if (pop) begin
                rd_ptr <= head_ptr + 1'b1;
                pend   <= avail_after_pop + CW'(push_ok);
            end else if (push_ok) begin
                pend <= pend + 1'b1;
            end
`else
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_segment_scheduler.sv
// tb/tb_segment_scheduler.sv - scoreboard bench for segment_scheduler
module tb_segment_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] seg_din = '0;
    logic        seg_push = 1'b0;
    logic        seg_full;
    logic [3:0]  seg_count;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fifo_full = 1'b0;
    logic        loop = 1'b0;
    logic        bank_swap, capture_en, busy, done;
    logic [7:0]  seg_index;
    logic        push_err, ovf_err;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    int          plan[$];

    always #5 clk = ~clk;

    segment_scheduler #(.DEPTH(8), .TW(16)) dut (
        .clk(clk), .reset(reset), .seg_din(seg_din), .seg_push(seg_push),
        .seg_full(seg_full), .seg_count(seg_count), .start(start), .abort(abort),
        .fifo_full(fifo_full),
`ifdef SEGMENT_SCHEDULER_LOOP_EN
        .loop(loop),
`endif
        .bank_swap(bank_swap), .capture_en(capture_en), .busy(busy), .done(done),
        .seg_index(seg_index), .push_err(push_err), .ovf_err(ovf_err)
    );

    // Monitor: one expected {bank_swap,capture_en,busy,done} per cycle.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({bank_swap, capture_en, busy, done} !== e) begin
                errors++;
                $display("FAIL ctl t=%0t act=%b exp=%b", $time,
                         {bank_swap, capture_en, busy, done}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int d);
        seg_din  = 16'(d);
        seg_push = 1'b1;
        tick();
        seg_push = 1'b0;
    endtask

    // Builds the expected strobe sequence from the plan and pulses start.
    task automatic begin_run();
        exp_q.push_back(4'b0000);
        foreach (plan[i]) begin
            exp_q.push_back(4'b1010);
            repeat (plan[i]) exp_q.push_back(4'b0110);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        check("reset_ctl", {bank_swap, capture_en, busy, done, push_err, ovf_err, seg_full}, 0);
        check("reset_idx", seg_index, 0);
        check("reset_cnt", seg_count, 0);

        // Basic single segment
        push(3);
        check("basic_count", seg_count, 1);
        plan = '{3};
        begin_run();
        wait_drain("basic_drain");
        check("basic_idx", seg_index, 1);

        // Two segments with a LOAD gap
        do_reset();
        push(2);
        push(4);
        plan = '{2, 4};
        begin_run();
        wait_drain("two_drain");
        check("two_idx", seg_index, 2);

        // Zero-duration followed by a 2-cycle segment
        do_reset();
        push(0);
        push(2);
        plan = '{0, 2};
        begin_run();
        wait_drain("zero_drain");
        check("zero_idx", seg_index, 2);

        // Full queue, dropped push, push accepted alongside a pop
        do_reset();
        for (int i = 1; i <= 9; i++) push(i);
        check("full_flag", seg_full, 1);
        check("full_count", seg_count, 8);
        check("full_push_err", push_err, 1);
`ifdef SEGMENT_SCHEDULER_LOOP_EN
        plan = '{1, 2, 3, 4, 5, 6, 7, 8};
        begin_run();
        check("full_err_clr", push_err, 0);
        wait_drain("full_drain");
        check("full_idx", seg_index, 8);
`else
        plan = '{1, 2, 3, 4, 5, 6, 7, 8, 2};
        begin_run();
        push(2);
        check("full_swap_count", seg_count, 8);
        check("full_err_clr", push_err, 0);
        wait_drain("full_drain");
        check("full_idx", seg_index, 9);
        check("full_empty", seg_count, 0);
`endif

        // Abort mid-run, overflow flag, then empty-queue start
        do_reset();
        push(100);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1010);
        repeat (10) exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        check("ovf_set", ovf_err, 1);
        repeat (8) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_count", seg_count, 0);
        check("abort_idx", seg_index, 1);
        check("abort_ovf_hold", ovf_err, 1);
        wait_drain("abort_drain");
        plan.delete();
        begin_run();
        check("empty_ovf_clr", ovf_err, 0);
        wait_drain("empty_drain");
        check("empty_idx", seg_index, 0);

`ifdef SEGMENT_SCHEDULER_LOOP_EN
        // Loop replay: two passes, loop dropped during the third segment
        do_reset();
        push(2);
        push(3);
        loop = 1'b1;
        plan = '{2, 3, 2, 3};
        begin_run();
        repeat (8) tick();
        loop = 1'b0;
        check("loop_idx3", seg_index, 3);
        wait_drain("loop_drain");
        check("loop_idx", seg_index, 4);
        check("loop_count", seg_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/segment_scheduler.md
Name: segment_scheduler

Overview:
- Sequences the synthesis datapath through a queue of timed output segments in the `clk` domain.
- At each segment boundary it issues a one-cycle bank-swap strobe, so the active amp/offset/phaseword banks reload from the staged banks.
- It gates the output-FIFO write enable for exactly the segment duration and pulses `done` when the queue is exhausted.
- It replaces ad-hoc countdown/timeup logic at top level with a queued, multi-segment run.

Parameters:
- `DEPTH`, 8, number of segment descriptors held in the queue (power of 2, at least 2).
- `TW`, 16, width of a segment duration in clk cycles.

Ports:
- `clk`  in  1  datapath clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; flushes queue, returns to IDLE.
- `seg_din`  in  TW  duration of the segment being pushed, in cycles.
- `seg_push`  in  1  push `seg_din` into the queue this cycle.
- `seg_full`  out  1  queue holds DEPTH entries.
- `seg_count`  out  $clog2(DEPTH)+1  entries currently queued.
- `start`  in  1  begin a run (single-cycle pulse).
- `abort`  in  1  stop the run immediately and flush the queue.
- `fifo_full`  in  1  full flag of the downstream output FIFO.
- `bank_swap`  out  1  one-cycle strobe: load active banks from staged banks.
- `capture_en`  out  1  output-FIFO write enable.
- `busy`  out  1  high in LOAD or RUN.
- `done`  out  1  one-cycle pulse at run completion.
- `seg_index`  out  8  number of segments loaded in the current run; wraps at 255→0.
- `push_err`  out  1  sticky: push attempted while the queue was full.
- `ovf_err`  out  1  sticky: `capture_en` asserted while `fifo_full` was high.

Behaviour:
- **Reset values:** all outputs 0, state IDLE, queue empty, cnt=0. `reset` has priority over `abort`, which has priority over everything else.
- **Queue:**
  - Circular FIFO.
  - A push while not full is accepted.
  - A push while full is dropped and sets `push_err`, except when the same cycle also pops, in which case the push is accepted and the count is unchanged.
  - Push and pop in the same cycle on a non-full queue leave the count unchanged.
- **States:** IDLE, LOAD, RUN, DONE. Outputs are decoded from the registered state (Moore).
- **IDLE:**
  - `start` with count>0 → LOAD.
  - `start` with count=0 → DONE.
  - `seg_index` clears to 0 on an accepted `start`.
- **LOAD (exactly 1 cycle):**
  - `bank_swap`=1.
  - Pop the head; cnt ← head duration D; `seg_index`++.
  - Next state: D≠0 → RUN; D=0 and queue non-empty after the pop → LOAD; otherwise → DONE.
- **RUN:**
  - `capture_en`=1; cnt decrements each cycle.
  - On the cycle with cnt=1: next state is LOAD if the queue is non-empty, else DONE.
  - RUN therefore lasts exactly D cycles per segment, and back-to-back segments have one non-capturing LOAD cycle between them.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Latency:** `start` sampled at edge t → `bank_swap` high in cycle t+1 → first `capture_en` in cycle t+2.
- **`start` outside IDLE:** ignored. Pushes during a run are allowed and extend the run if they land before the last segment's final RUN cycle.
- **`abort`:** from any state → IDLE next cycle. Queue flushed; `capture_en`, `bank_swap`, `busy` drop next cycle. No `done` pulse. `seg_index`, `push_err`, `ovf_err` hold.
- **`fifo_full`:** does not stall the sequence (the timebase is fixed). If `capture_en` & `fifo_full`, set `ovf_err`.
- **Sticky errors:** `push_err` and `ovf_err` clear only on `reset` or on an accepted `start`.

Optional Feature:
- Macro `SEGMENT_SCHEDULER_LOOP_EN`.
- **Defined:**
  - Adds input port `loop` (1 bit).
  - Popped entries stay resident; the read pointer advances, but entries are not freed until `abort` or `reset`.
  - When the last resident entry finishes with `loop`=1, the next state is LOAD with the read pointer rewound to the first resident entry. `seg_index` keeps counting. No `done` pulse.
  - Deasserting `loop` lets the current pass finish, then DONE.
  - `seg_count` and `seg_full` reflect resident entries.
- **Undefined:** no `loop` port; entries are consumed on pop exactly as described above.

Test Plan:
- **Basic run:** push 3; `start` → `bank_swap` in cycle 1, `capture_en` high cycles 2–4, `done` in cycle 5, `busy` low after.
- **Two segments:** push 2, push 4; `start` → `capture_en` 2 cycles, 1-cycle gap with `bank_swap`, `capture_en` 4 cycles, `done`; `seg_index`=2.
- **Zero-duration and empty cases:**
  - Push 0, push 2; `start` → two consecutive `bank_swap` cycles, then 2 `capture_en`.
  - `start` on an empty queue → `done` one cycle after `start`, no `bank_swap`.
- **Full queue:** push 9 entries (DEPTH=8) → `seg_full`=1, `seg_count`=8, `push_err`=1; run drains 8 segments.
- **Abort and overflow:** push 100; `start`; `abort` in 10th RUN cycle → next cycle `capture_en`=0, `busy`=0, `seg_count`=0, no `done`. Hold `fifo_full`=1 during any RUN cycle → `ovf_err`=1, persists until next `start`.
- **Loop (`SEGMENT_SCHEDULER_LOOP_EN`):** push 2, 3, `loop`=1, `start` → pattern 2/gap/3/gap repeats with `seg_index` 1,2,3,4…. Drop `loop` during the 3rd segment → the pass ends with `done` after the 4th segment; `seg_count` stays 2.
